vx_csr_sched_agent: RTL and testbench

- Scheduler-side responder for the scheduler/CSR handshake used by the CSR unit.
- Tracks per-warp in-flight instruction counts and answers almost-empty queries for a requested warp.
- Locks a warp when an FPU-CSR instruction issues and unlocks it on the CSR unit's unlock pulse.
- Sources the free-running cycle counter exported to CSR reads; sits inside the scheduler, between issue/commit tracking and the CSR unit.

---
 rtl/vx_csr_sched_agent.sv | 145 ++++++++++++++
 tb/tb_vx_csr_sched_agent.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_csr_sched_agent.sv
// Scheduler-side agent for the CSR handshake: pending counts, warp locks, cycle counter.
// Optional LOCK_TIMEOUT_EN adds a per-warp lock watchdog driving a sticky timeout_err.
module vx_csr_sched_agent #(
  parameter int NUM_WARPS    = 4,
  parameter int NW_WIDTH     = 2,
  parameter int PEND_SIZE    = 15,
  parameter int CYCLE_W      = 64,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [NW_WIDTH-1:0]  issue_wid,
  input  logic                 issue_lock,
  input  logic                 commit_valid,
  input  logic [NW_WIDTH-1:0]  commit_wid,
  input  logic [NW_WIDTH-1:0]  alm_empty_wid,
  output logic                 alm_empty,
  input  logic                 unlock_warp,
  input  logic [NW_WIDTH-1:0]  unlock_wid,
  output logic [NUM_WARPS-1:0] warp_locked,
  output logic [NUM_WARPS-1:0] warp_full,
  output logic [CYCLE_W-1:0]   cycles,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(PEND_SIZE + 1);
  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(PEND_SIZE);

  logic [CNT_W-1:0]     cnt_q [NUM_WARPS];
  logic [CNT_W-1:0]     cnt_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] inc;
  logic [NUM_WARPS-1:0] dec;
  logic [NUM_WARPS-1:0] lock_set;
  logic [NUM_WARPS-1:0] lock_clr;
  logic [NUM_WARPS-1:0] locked_d, locked_q;
  logic [CYCLE_W-1:0]   cycles_d, cycles_q;

  // Decode issue/commit/lock events into per-warp strobes.
  always_comb begin
    inc      = '0;
    dec      = '0;
    lock_set = '0;
    lock_clr = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc[w] = issue_valid && (issue_wid == NW_WIDTH'(w));
      dec[w] = commit_valid && (commit_wid == NW_WIDTH'(w));
      lock_set[w] = inc[w] && issue_lock;
      lock_clr[w] = unlock_warp && (unlock_wid == NW_WIDTH'(w));
    end
  end

  // Next pending counts; saturate at both ends, same-warp issue+commit cancels.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      cnt_d[w] = cnt_q[w];
      if (inc[w] && !dec[w] && cnt_q[w] != PEND_MAX)
        cnt_d[w] = cnt_q[w] + CNT_W'(1);
      else if (dec[w] && !inc[w] && cnt_q[w] != '0)
        cnt_d[w] = cnt_q[w] - CNT_W'(1);
    end
  end

  // Lock mask next state; a new lock beats a same-cycle unlock.
  always_comb begin
    locked_d = (locked_q & ~lock_clr) | lock_set;
    cycles_d = cycles_q + CYCLE_W'(1);
  end

  // State registers for counters, locks and cycle count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++)
        cnt_q[w] <= '0;
      locked_q <= '0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      cycles_q <= cycles_d;
    end
  end

  // Combinational status outputs from registered state.
  always_comb begin
    warp_full = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      warp_full[w] = (cnt_q[w] == PEND_MAX);
    alm_empty   = (cnt_q[alm_empty_wid] <= CNT_W'(1));
    warp_locked = locked_q;
    cycles      = cycles_q;
  end

`ifdef LOCK_TIMEOUT_EN
  localparam int WD_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LOCK_TIMEOUT);

  logic [WD_W-1:0]      wd_q [NUM_WARPS];
  logic [WD_W-1:0]      wd_d [NUM_WARPS];
  logic [NUM_WARPS-1:0] wd_hit;
  logic                 err_d, err_q;

  // Watchdog restarts on lock, counts while locked, sticks at the limit.
  always_comb begin
    wd_hit = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      wd_d[w] = wd_q[w];
      if (lock_set[w])
        wd_d[w] = '0;
      else if (locked_q[w] && wd_q[w] != WD_MAX)
        wd_d[w] = wd_q[w] + WD_W'(1);
      wd_hit[w] = locked_q[w] && (wd_q[w] == WD_MAX);
    end
    err_d = err_q | (|wd_hit);
  end

  // Watchdog counters and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++)
        wd_q[w] <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Protocol misuse checks from the issue/commit side.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(issue_valid && warp_full[issue_wid] &&
                !(commit_valid && commit_wid == issue_wid)));
      assert (!(commit_valid && cnt_q[commit_wid] == '0 &&
                !(issue_valid && commit_wid == issue_wid)));
      assert (!(issue_valid && locked_q[issue_wid]));
    end
  end

endmodule

// File: tb/tb_vx_csr_sched_agent.sv
// Directed bench for vx_csr_sched_agent.
// Built with LOCK_TIMEOUT=8 so the watchdog path is short when enabled.
module tb_vx_csr_sched_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_lock;
  logic [1:0]  issue_wid;
  logic        commit_valid;
  logic [1:0]  commit_wid;
  logic [1:0]  alm_empty_wid;
  logic        alm_empty;
  logic        unlock_warp;
  logic [1:0]  unlock_wid;
  logic [3:0]  warp_locked, warp_full;
  logic [63:0] cycles;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  vx_csr_sched_agent #(
    .NUM_WARPS(4), .NW_WIDTH(2), .PEND_SIZE(15),
    .CYCLE_W(64), .LOCK_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wid(issue_wid),
    .issue_lock(issue_lock),
    .commit_valid(commit_valid), .commit_wid(commit_wid),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm_empty),
    .unlock_warp(unlock_warp), .unlock_wid(unlock_wid),
    .warp_locked(warp_locked), .warp_full(warp_full),
    .cycles(cycles), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    issue_valid = 0; issue_wid = 0; issue_lock = 0;
    commit_valid = 0; commit_wid = 0;
    unlock_warp = 0; unlock_wid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic cyc(input logic iv, input logic [1:0] iw,
                     input logic il, input logic cv,
                     input logic [1:0] cw, input logic uv,
                     input logic [1:0] uw);
    issue_valid = iv; issue_wid = iw; issue_lock = il;
    commit_valid = cv; commit_wid = cw;
    unlock_warp = uv; unlock_wid = uw;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    alm_empty_wid = 0;
    reset = 1;
    #12;
    tests++;
    if (cycles !== 64'd0) begin
      fails++; $display("FAIL reset_cycles: got %0d want 0", cycles);
    end
    tests++;
    if (warp_locked !== 4'b0000) begin
      fails++; $display("FAIL reset_locked: got %b want 0000", warp_locked);
    end
    tests++;
    if (warp_full !== 4'b0000) begin
      fails++; $display("FAIL reset_full: got %b want 0000", warp_full);
    end
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL reset_terr: got %b want 0", timeout_err);
    end
    for (int w = 0; w < 4; w++) begin
      alm_empty_wid = 2'(w);
      #1;
      tests++;
      if (alm_empty !== 1'b1) begin
        fails++; $display("FAIL reset_alm w%0d: got %b want 1", w, alm_empty);
      end
    end
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (cycles !== 64'd5) begin
      fails++; $display("FAIL cycles5: got %0d want 5", cycles);
    end
  endtask

  task automatic test_pending();
    alm_empty_wid = 2'd1;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);
    tests++;
    if (alm_empty !== 1'b0) begin
      fails++; $display("FAIL pend3_alm: got %b want 0", alm_empty);
    end
    cyc(0, 0, 0, 1, 1, 0, 0);
    tests++;
    if (alm_empty !== 1'b0) begin
      fails++; $display("FAIL pend2_alm: got %b want 0", alm_empty);
    end
    cyc(0, 0, 0, 1, 1, 0, 0);
    tests++;
    if (alm_empty !== 1'b1) begin
      fails++; $display("FAIL pend1_alm: got %b want 1", alm_empty);
    end
    cyc(0, 0, 0, 1, 1, 0, 0);
    tests++;
    if (alm_empty !== 1'b1) begin
      fails++; $display("FAIL pend0_alm: got %b want 1", alm_empty);
    end
    alm_empty_wid = 2'd0;
    #1;
    tests++;
    if (alm_empty !== 1'b1) begin
      fails++; $display("FAIL pend_other_alm: got %b want 1", alm_empty);
    end
  endtask

  task automatic test_same_cycle();
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0, 0);
    cyc(1, 2, 0, 1, 2, 0, 0);
    alm_empty_wid = 2'd2;
    #1;
    tests++;
    if (alm_empty !== 1'b0) begin
      fails++; $display("FAIL same_wid_hold: got %b want 0", alm_empty);
    end
    cyc(0, 0, 0, 1, 2, 0, 0);
    tests++;
    if (alm_empty !== 1'b1) begin
      fails++; $display("FAIL same_wid_after: got %b want 1", alm_empty);
    end
    cyc(0, 0, 0, 1, 2, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 3, 0, 0);
    alm_empty_wid = 2'd0;
    #1;
    tests++;
    if (alm_empty !== 1'b0) begin
      fails++; $display("FAIL diff_wid_inc: got %b want 0", alm_empty);
    end
    alm_empty_wid = 2'd3;
    #1;
    tests++;
    if (alm_empty !== 1'b1) begin
      fails++; $display("FAIL diff_wid_dec: got %b want 1", alm_empty);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 0, 0);
  endtask

  task automatic test_lock();
    cyc(1, 1, 1, 0, 0, 0, 0);
    tests++;
    if (warp_locked !== 4'b0010) begin
      fails++; $display("FAIL lock_set: got %b want 0010", warp_locked);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    tests++;
    if (warp_locked !== 4'b0000) begin
      fails++; $display("FAIL lock_clr: got %b want 0000", warp_locked);
    end
    cyc(0, 0, 0, 0, 0, 1, 1);
    tests++;
    if (warp_locked !== 4'b0000) begin
      fails++; $display("FAIL unlock_idle: got %b want 0000", warp_locked);
    end
    cyc(1, 2, 1, 0, 0, 1, 2);
    tests++;
    if (warp_locked !== 4'b0100) begin
      fails++; $display("FAIL set_wins: got %b want 0100", warp_locked);
    end
    cyc(0, 0, 0, 1, 1, 1, 2);
    tests++;
    if (warp_locked !== 4'b0000) begin
      fails++; $display("FAIL lock_clr2: got %b want 0000", warp_locked);
    end
    cyc(0, 0, 0, 1, 2, 0, 0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (warp_full !== 4'b0000) begin
      fails++; $display("FAIL full14: got %b want 0000", warp_full);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    tests++;
    if (warp_full !== 4'b0001) begin
      fails++; $display("FAIL full15: got %b want 0001", warp_full);
    end
    cyc(0, 0, 0, 1, 0, 0, 0);
    tests++;
    if (warp_full !== 4'b0000) begin
      fails++; $display("FAIL full_drop: got %b want 0000", warp_full);
    end
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    alm_empty_wid = 2'd0;
    #1;
    tests++;
    if (alm_empty !== 1'b1) begin
      fails++; $display("FAIL full_drain: got %b want 1", alm_empty);
    end
  endtask

  task automatic test_timeout();
    logic exp_err;
`ifdef LOCK_TIMEOUT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    cyc(1, 3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL terr_early: got %b want 0", timeout_err);
    end
    for (int i = 0; i < 9; i++) tick();
    tests++;
    if (timeout_err !== exp_err) begin
      fails++;
      $display("FAIL terr_hold: got %b want %b", timeout_err, exp_err);
    end
    tests++;
    if (warp_locked !== 4'b1000) begin
      fails++; $display("FAIL terr_lock: got %b want 1000", warp_locked);
    end
    cyc(0, 0, 0, 1, 3, 1, 3);
    tick();
    tests++;
    if (timeout_err !== exp_err) begin
      fails++;
      $display("FAIL terr_sticky: got %b want %b", timeout_err, exp_err);
    end
    tests++;
    if (warp_locked !== 4'b0000) begin
      fails++; $display("FAIL terr_unlock: got %b want 0000", warp_locked);
    end
  endtask

  task automatic test_cycles();
    logic [63:0] c0;
    c0 = cycles;
    for (int i = 0; i < 7; i++) tick();
    tests++;
    if (cycles !== c0 + 64'd7) begin
      fails++; $display("FAIL cycles_run: got %0d want %0d", cycles, c0 + 64'd7);
    end
  endtask

  initial begin
    test_reset();
    test_pending();
    test_same_cycle();
    test_lock();
    test_full();
    test_timeout();
    test_cycles();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
